vga_line_fetch: RTL and testbench

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

---
 rtl/vga_line_fetch_pkg.sv | 28 ++
 rtl/line_buf_2bank.sv | 31 +++
 rtl/vga_line_fetch.sv | 184 ++++++++++++++++++
 tb/tb_vga_line_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_line_fetch_pkg.sv
// Shared definitions for the VGA line-fetch block: system state codes,
// fetch-FSM encoding and RGB444 pixel fields.
package vga_line_fetch_pkg;

    localparam logic [7:0] ST_WAIT = 8'h01;
    localparam logic [7:0] ST_LOAD = 8'h02;
    localparam logic [7:0] ST_DISP = 8'h03;

    typedef enum logic {
        FS_IDLE  = 1'b0,
        FS_FETCH = 1'b1
    } fetch_st_e;

    localparam int unsigned RGB_PW = 12;
    localparam int unsigned RGB_CW = 4;

    typedef struct packed {
        logic [RGB_CW-1:0] r;
        logic [RGB_CW-1:0] g;
        logic [RGB_CW-1:0] b;
    } rgb444_t;

    // Index width for an n-entry structure; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buf_2bank.sv
// Two-bank ping-pong line buffer: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module line_buf_2bank
    import vga_line_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned PW    = 12,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic          wr_bank_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [PW-1:0] wr_data_i,
    input  logic          rd_bank_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [PW-1:0] rd_data_c
);

    logic [PW-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i && (32'(wr_idx_i) < DEPTH)) begin
            mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
        end
    end

    // Out-of-range indices read as zero rather than an undefined entry.
    assign rd_data_c = (32'(rd_idx_i) < DEPTH) ? mem_q[rd_bank_i][rd_idx_i] : '0;

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one image line from SPRAM into a ping-pong buffer per rd_sig and
// streams the other bank out as pixels. Define VGA_TESTPAT_EN to replace the
// displayed pixel with a coordinate test pattern.
module vga_line_fetch
    import vga_line_fetch_pkg::*;
#(
    parameter int unsigned W        = 200,
    parameter int unsigned H        = 150,
    parameter int unsigned STARTROW = 0,
    parameter int unsigned STARTCOL = 0,
    parameter int unsigned AW       = 16,
    parameter int unsigned PW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    state,
    input  logic          rd_sig,
    input  logic [11:0]   xpos,
    input  logic [11:0]   ypos,
    input  logic          hs_in,
    input  logic          vs_in,
    output logic [AW-1:0] spram_addr,
    output logic          spram_rd_en,
    input  logic [PW-1:0] spram_rdata,
    output logic [PW-1:0] pix_rgb,
    output logic          de,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          overrun
);

    localparam int unsigned IW = idx_width(W);
    localparam int unsigned LW = idx_width(H);

    fetch_st_e     fsm_q;
    logic [LW-1:0] line_cnt_q;
    logic [IW-1:0] idx_q;
    logic          fetch_bank_q;
    logic [AW-1:0] spram_addr_q;
    logic          rd_en_q;
    logic          overrun_q;

    logic          wr_en_q;
    logic [IW-1:0] wr_idx_q;
    logic          wr_bank_q;

    logic [PW-1:0] pix_q,  pix_d;
    logic          de_q,   de_d;
    logic          hs_q;
    logic          vs_q;

    logic          disp_c;
    logic [AW-1:0] line_base_c;
    logic [LW-1:0] line_nxt_c;
    logic          rd_bank_c;
    logic [IW-1:0] rd_idx_c;
    logic [PW-1:0] buf_rdata_c;

    assign disp_c      = (state == ST_DISP);
    assign line_base_c = AW'(32'(line_cnt_q) * W);
    assign line_nxt_c  = (32'(line_cnt_q) == H - 1) ? '0 : line_cnt_q + LW'(1);
    assign rd_bank_c   = ~line_cnt_q[0];

    // Fetch FSM: issues W consecutive SPRAM reads per accepted rd_sig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= FS_IDLE;
            line_cnt_q   <= '0;
            idx_q        <= '0;
            fetch_bank_q <= 1'b0;
            spram_addr_q <= '0;
            rd_en_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (!disp_c) begin
            fsm_q      <= FS_IDLE;
            line_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            unique case (fsm_q)
                FS_IDLE: begin
                    if (rd_sig) begin
                        fsm_q        <= FS_FETCH;
                        spram_addr_q <= line_base_c;
                        idx_q        <= '0;
                        fetch_bank_q <= line_cnt_q[0];
                        line_cnt_q   <= line_nxt_c;
                        rd_en_q      <= 1'b1;
                    end
                end
                FS_FETCH: begin
                    if (rd_sig) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == IW'(W - 1)) begin
                        fsm_q   <= FS_IDLE;
                        rd_en_q <= 1'b0;
                    end else begin
                        idx_q        <= idx_q + IW'(1);
                        spram_addr_q <= spram_addr_q + AW'(1);
                    end
                end
                default: begin
                    fsm_q   <= FS_IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data returns one cycle after its strobe; delay the buffer write to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            wr_en_q   <= rd_en_q;
            wr_idx_q  <= idx_q;
            wr_bank_q <= fetch_bank_q;
        end
    end

    line_buf_2bank #(
        .DEPTH (W),
        .PW    (PW),
        .IW    (IW)
    ) u_line_buf (
        .clk       (clk),
        .wr_en_i   (wr_en_q),
        .wr_bank_i (wr_bank_q),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (spram_rdata),
        .rd_bank_i (rd_bank_c),
        .rd_idx_i  (rd_idx_c),
        .rd_data_c (buf_rdata_c)
    );

    // Image window decode and pixel select.
    always_comb begin
        de_d     = (32'(xpos) >= STARTCOL) && (32'(xpos) < STARTCOL + W) &&
                   (32'(ypos) >= STARTROW) && (32'(ypos) < STARTROW + H);
        rd_idx_c = de_d ? IW'(xpos - 12'(STARTCOL)) : '0;
        pix_d    = '0;
`ifdef VGA_TESTPAT_EN
        if (de_d) begin
            pix_d = PW'(rgb444_t'{r: xpos[3:0], g: ypos[3:0], b: xpos[3:0] ^ ypos[3:0]});
        end
`else
        if (de_d) begin
            pix_d = buf_rdata_c;
        end
`endif
    end

    // Output stage; syncs keep their one-cycle delay in every system state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            if (disp_c) begin
                pix_q <= pix_d;
                de_q  <= de_d;
            end else begin
                pix_q <= '0;
                de_q  <= 1'b0;
            end
        end
    end

    assign spram_addr  = spram_addr_q;
    assign spram_rd_en = rd_en_q;
    assign overrun     = overrun_q;
    assign pix_rgb     = pix_q;
    assign de          = de_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a small 4x2 image offset in the display.
module tb_vga_line_fetch;
    import vga_line_fetch_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned SC = 2;
    localparam int unsigned SR = 1;
    localparam int unsigned AW = 16;
    localparam int unsigned PW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    state;
    logic          rd_sig;
    logic [11:0]   xpos;
    logic [11:0]   ypos;
    logic          hs_in;
    logic          vs_in;
    logic [AW-1:0] spram_addr;
    logic          spram_rd_en;
    logic [PW-1:0] spram_rdata = '0;
    logic [PW-1:0] pix_rgb;
    logic          de;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          overrun;

    logic [11:0]   data_ofs;
    logic          gap_en;
    int            gap = 1000;
    int            n_chk = 0;
    int            n_bad = 0;
    int            cnt;

    vga_line_fetch #(
        .W        (W),
        .H        (H),
        .STARTROW (SR),
        .STARTCOL (SC),
        .AW       (AW),
        .PW       (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .rd_sig      (rd_sig),
        .xpos        (xpos),
        .ypos        (ypos),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .spram_addr  (spram_addr),
        .spram_rd_en (spram_rd_en),
        .spram_rdata (spram_rdata),
        .pix_rgb     (pix_rgb),
        .de          (de),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // SPRAM model: data = address + offset, one cycle after the strobe.
    always @(posedge clk) begin
        if (spram_rd_en) spram_rdata <= 12'(spram_addr) + data_ofs;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line fetches must be at least W+2 cycles apart.
    always @(posedge clk) begin
        if (!gap_en) begin
            gap = 1000;
        end else if (rd_sig && state == ST_DISP) begin
            chk("line_period", 32'(gap >= int'(W + 2)), 32'd1);
            gap = 0;
        end else if (gap < 1000) begin
            gap++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] base);
        rd_sig = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            step();
            rd_sig = 1'b0;
            chk("fetch_en", 32'(spram_rd_en), 32'd1);
            chk("fetch_addr", 32'(spram_addr), 32'(base) + 32'(i));
        end
        step();
        chk("fetch_end", 32'(spram_rd_en), 32'd0);
        step();
    endtask

    task automatic show(input int x, input int y, input logic [11:0] pexp, input logic dexp);
        logic [11:0] xv;
        logic [11:0] yv;
        logic [11:0] e;
        xv = 12'(x);
        yv = 12'(y);
        e  = pexp;
`ifdef VGA_TESTPAT_EN
        if (dexp) e = {xv[3:0], yv[3:0], xv[3:0] ^ yv[3:0]};
`endif
        xpos = xv;
        ypos = yv;
        step();
        chk("de", 32'(de), 32'(dexp));
        chk("pix", 32'(pix_rgb), 32'(e));
    endtask

    task automatic count_en(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c += int'(spram_rd_en);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = ST_DISP;
        rd_sig   = 1'b0;
        xpos     = 12'hFFF;
        ypos     = 12'hFFF;
        hs_in    = 1'b0;
        vs_in    = 1'b0;
        data_ofs = 12'h100;
        gap_en   = 1'b1;
        #12;
        chk("rst_addr", 32'(spram_addr), 32'd0);
        chk("rst_en", 32'(spram_rd_en), 32'd0);
        chk("rst_pix", 32'(pix_rgb), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hs", 32'(VGA_HS), 32'd1);
        chk("rst_vs", 32'(VGA_VS), 32'd1);
        chk("rst_ovr", 32'(overrun), 32'd0);
        hs_in = 1'b1;
        vs_in = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Line 0, then window boundaries.
        do_fetch(16'd0);
        for (int i = 0; i < int'(W); i++) show(int'(SC) + i, int'(SR), 12'h100 + 12'(i), 1'b1);
        show(int'(SC + W), int'(SR), 12'h000, 1'b0);
        show(int'(SC) - 1, int'(SR), 12'h000, 1'b0);
        show(int'(SC), int'(SR + H), 12'h000, 1'b0);
        show(int'(SC), int'(SR) - 1, 12'h000, 1'b0);
        show(12'hFFF, int'(SR), 12'h000, 1'b0);

        // Line 1 lands in the other bank.
        do_fetch(16'd4);
        show(int'(SC), int'(SR) + 1, 12'h104, 1'b1);
        show(int'(SC) + 3, int'(SR) + 1, 12'h107, 1'b1);

        // Line counter wraps back to line 0.
        data_ofs = 12'h200;
        do_fetch(16'd0);
        show(int'(SC), int'(SR), 12'h200, 1'b1);
        show(int'(SC) + 2, int'(SR), 12'h202, 1'b1);

        // Second rd_sig during a fetch is dropped and flagged.
        chk("ovr_pre", 32'(overrun), 32'd0);
        gap_en = 1'b0;
        rd_sig = 1'b1;
        step();
        chk("ovr_addr", 32'(spram_addr), 32'd4);
        cnt = int'(spram_rd_en);
        rd_sig = 1'b0;
        step();
        cnt += int'(spram_rd_en);
        rd_sig = 1'b1;
        step();
        cnt += int'(spram_rd_en);
        rd_sig = 1'b0;
        begin
            int c;
            count_en(8, c);
            cnt += c;
        end
        chk("ovr_strobes", 32'(cnt), 32'(W));
        chk("ovr_set", 32'(overrun), 32'd1);
        state = ST_LOAD;
        xpos  = 12'(SC);
        ypos  = 12'(SR);
        step();
        chk("ovr_clr", 32'(overrun), 32'd0);
        chk("load_de", 32'(de), 32'd0);
        chk("load_pix", 32'(pix_rgb), 32'd0);

        // Non-display state: no fetches, syncs still delayed.
        state = ST_WAIT;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd_sig = ~rd_sig;
            step();
            cnt += int'(spram_rd_en);
        end
        rd_sig = 1'b0;
        chk("wait_strobes", 32'(cnt), 32'd0);
        hs_in = 1'b0;
        step();
        chk("hs_dly", 32'(VGA_HS), 32'd0);
        chk("vs_hold", 32'(VGA_VS), 32'd1);
        hs_in = 1'b1;
        vs_in = 1'b0;
        step();
        chk("hs_rel", 32'(VGA_HS), 32'd1);
        chk("vs_dly", 32'(VGA_VS), 32'd0);
        vs_in = 1'b1;

        // Reset at the second strobe aborts the fetch.
        state = ST_DISP;
        step();
        rd_sig = 1'b1;
        step();
        rd_sig = 1'b0;
        chk("ab_en1", 32'(spram_rd_en), 32'd1);
        step();
        chk("ab_addr2", 32'(spram_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ab_en_rst", 32'(spram_rd_en), 32'd0);
        chk("ab_addr_rst", 32'(spram_addr), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        count_en(8, cnt);
        chk("ab_idle", 32'(cnt), 32'd0);

        // Refill after reset restarts at line 0.
        data_ofs = 12'h300;
        do_fetch(16'd0);
        show(int'(SC) + 1, int'(SR), 12'h301, 1'b1);
        show(int'(SC) + 3, int'(SR), 12'h303, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
